// File: rtl/alu_program_sequencer.sv
// Program sequencer for the ALU instruction decoder: writable program memory, PC, run/step issue.
// Optional build macro SEQ_LOOP_EN turns opcode 4'hE into a bounded loop-back marker.
module alu_program_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int MAX_LOOPS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [3:0]        prog_data,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              halt_req,
  output logic [3:0]        instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              prog_err
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;

  localparam logic [3:0]        OP_IDLE   = 4'hF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

  state_t            state, state_nx;
  logic [3:0]        mem [PROG_DEPTH];
  logic [3:0]        fetch_op;
  logic              do_fetch;
  logic [ADDR_W-1:0] pc_nx;
  logic [3:0]        instr_nx;
  logic              valid_nx, done_nx, err_nx;

`ifdef SEQ_LOOP_EN
  localparam int LOOP_W = (MAX_LOOPS < 1) ? 1 : $clog2(MAX_LOOPS + 1);
  logic [LOOP_W-1:0] loop_cnt, loop_cnt_nx;
`endif

  assign fetch_op = mem[pc];
  assign busy     = (state == RUN) || (state == STEP);

  // NOTE: program memory has no reset branch so it maps onto plain RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) mem[prog_addr] <= prog_data;
  end

  // NOTE: every next-value signal is defaulted first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = OP_IDLE;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = prog_err;
    do_fetch = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_cnt_nx = loop_cnt;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          if (halt_req) begin
            err_nx = 1'b1;
          end else begin
            pc_nx    = '0;
            err_nx   = 1'b0;
            state_nx = step_mode ? STEP : RUN;
`ifdef SEQ_LOOP_EN
            loop_cnt_nx = '0;
`endif
          end
        end
      end
      RUN, STEP: begin
        if (prog_we) err_nx = 1'b1;
        if (halt_req) state_nx = IDLE;
        else          do_fetch = (state == RUN) || step;
      end
      DONE: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Halt opcode and loop marker are consumed here and never reach the decoder.
    if (do_fetch) begin
      if (fetch_op == OP_IDLE) begin
        state_nx = DONE;
      end
`ifdef SEQ_LOOP_EN
      else if (fetch_op == 4'hE) begin
        if (loop_cnt < LOOP_W'(MAX_LOOPS)) begin
          pc_nx       = '0;
          loop_cnt_nx = loop_cnt + 1'b1;
        end else begin
          state_nx = DONE;
        end
      end
`endif
      else begin
        instr_nx = fetch_op;
        valid_nx = 1'b1;
        if (pc == LAST_ADDR) state_nx = DONE;
        else                 pc_nx    = pc + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= OP_IDLE;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      prog_err    <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_cnt    <= '0;
`endif
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instruction <= instr_nx;
      instr_valid <= valid_nx;
      done        <= done_nx;
      prog_err    <= err_nx;
`ifdef SEQ_LOOP_EN
      loop_cnt    <= loop_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Directed self-checking bench for alu_program_sequencer; expectations hand-derived per step.
module tb_alu_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [3:0] prog_data;
  logic       start, step_mode, step, halt_req;
  logic [3:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy, done, prog_err;

  int checks = 0;
  int errors = 0;

  alu_program_sequencer #(.PROG_DEPTH(16), .ADDR_W(4), .MAX_LOOPS(2)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .step_mode(step_mode), .step(step),
    .halt_req(halt_req), .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .busy(busy), .done(done), .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic halt_now();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
  endtask

  logic [3:0] t3_ops [3];
  logic [3:0] t6_ops [16];
  logic [3:0] lp_ops [6];
  logic       lp_val [6];
  logic [3:0] lp_pc  [6];

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
    #2;
    check("rst_instr", instruction, 4'hF);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_pc",    pc,          4'd0);
    check("rst_busy",  busy,        1'b0);
    check("rst_done",  done,        1'b0);
    check("rst_err",   prog_err,    1'b0);
    @(negedge clk); reset = 1'b0;
    tick();

    // Test 1: basic run ending on halt opcode
    wr(0, 4'h1); wr(1, 4'h2); wr(2, 4'h5); wr(3, 4'hF);
    start = 1'b1; step_mode = 1'b0;
    tick(); start = 1'b0;
    check("t1_busy",   busy,        1'b1);
    check("t1_lat",    instr_valid, 1'b0);
    tick(); check("t1_op0", instruction, 4'h1); check("t1_v0", instr_valid, 1'b1); check("t1_pc0", pc, 4'd1);
    tick(); check("t1_op1", instruction, 4'h2); check("t1_pc1", pc, 4'd2);
    tick(); check("t1_op2", instruction, 4'h5); check("t1_v2", instr_valid, 1'b1); check("t1_pc2", pc, 4'd3);
    tick(); check("t1_halt_op", instruction, 4'hF); check("t1_halt_v", instr_valid, 1'b0);
    check("t1_halt_pc", pc, 4'd3); check("t1_halt_busy", busy, 1'b0); check("t1_halt_done", done, 1'b0);
    tick(); check("t1_done", done, 1'b1); check("t1_done_op", instruction, 4'hF); check("t1_done_pc", pc, 4'd3);
    tick(); check("t1_done_clr", done, 1'b0);

    // Test 2: full memory, end-of-memory completion without wrap
    for (int i = 0; i < 16; i++) wr(4'(i), 4'h4);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t2_op", instruction, 4'h4);
      check("t2_v",  instr_valid, 1'b1);
      check("t2_pc", pc, (i < 15) ? 8'(i + 1) : 8'd15);
    end
    check("t2_end_busy", busy, 1'b0);
    tick(); check("t2_done", done, 1'b1); check("t2_pc_nowrap", pc, 4'd15);
    check("t2_end_op", instruction, 4'hF); check("t2_end_v", instr_valid, 1'b0);
    tick();

    // Test 3: step mode
    wr(0, 4'h1); wr(1, 4'h3); wr(2, 4'h6); wr(3, 4'hF);
    t3_ops[0] = 4'h1; t3_ops[1] = 4'h3; t3_ops[2] = 4'h6;
    start = 1'b1; step_mode = 1'b1; tick(); start = 1'b0; step_mode = 1'b0;
    for (int s = 0; s < 3; s++) begin
      repeat (5) begin
        tick();
        check("t3_gap_op", instruction, 4'hF);
        check("t3_gap_v",  instr_valid, 1'b0);
      end
      step = 1'b1; tick(); step = 1'b0;
      check("t3_op", instruction, t3_ops[s]);
      check("t3_v",  instr_valid, 1'b1);
      check("t3_pc", pc, 8'(s + 1));
    end
    tick(); check("t3_after_op", instruction, 4'hF); check("t3_busy", busy, 1'b1);
    halt_now();
    check("t3_halt_busy", busy, 1'b0); check("t3_halt_pc", pc, 4'd3);

    // Test 4: halt_req after second issue
    for (int i = 0; i < 4; i++) wr(4'(i), 4'h4);
    wr(4, 4'hF);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("t4_op2", instruction, 4'h4); check("t4_pc2", pc, 4'd2);
    halt_now();
    check("t4_op",   instruction, 4'hF); check("t4_v", instr_valid, 1'b0);
    check("t4_busy", busy, 1'b0);        check("t4_done", done, 1'b0);
    check("t4_pc",   pc, 4'd2);
    tick(); check("t4_done_later", done, 1'b0);

    // Test 5: write while busy, start+halt_req, write+start
    start = 1'b1; tick(); start = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'h7; tick(); prog_we = 1'b0;
    check("t5_err", prog_err, 1'b1); check("t5_op", instruction, 4'h4);
    halt_now();
    check("t5_err_sticky", prog_err, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_err_clr", prog_err, 1'b0); check("t5_rerun_busy", busy, 1'b1);
    tick(); check("t5_mem_kept", instruction, 4'h4);
    halt_now();
    start = 1'b1; halt_req = 1'b1; tick(); start = 1'b0; halt_req = 1'b0;
    check("t5_sh_busy", busy, 1'b0); check("t5_sh_err", prog_err, 1'b1);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'h9; start = 1'b1;
    tick(); prog_we = 1'b0; start = 1'b0;
    check("t5_ws_busy", busy, 1'b1); check("t5_ws_err", prog_err, 1'b0);
    tick(); check("t5_ws_op", instruction, 4'h9); check("t5_ws_v", instr_valid, 1'b1);

    // Asynchronous reset mid-run
    tick();
    #2 reset = 1'b1;
    #1;
    check("ar_instr", instruction, 4'hF); check("ar_valid", instr_valid, 1'b0);
    check("ar_pc", pc, 4'd0); check("ar_busy", busy, 1'b0);
    @(negedge clk); reset = 1'b0;
    tick();

    // Test 6: loop marker (or plain NOP without the macro)
    t6_ops[0] = 4'h5; t6_ops[1] = 4'hE; t6_ops[2] = 4'hC; t6_ops[3] = 4'hD;
    for (int i = 4; i < 16; i++) t6_ops[i] = 4'h4;
    for (int i = 0; i < 16; i++) wr(4'(i), t6_ops[i]);
    start = 1'b1; tick(); start = 1'b0;
`ifdef SEQ_LOOP_EN
    lp_ops[0] = 4'h5; lp_ops[1] = 4'hF; lp_ops[2] = 4'h5; lp_ops[3] = 4'hF; lp_ops[4] = 4'h5; lp_ops[5] = 4'hF;
    lp_val[0] = 1'b1; lp_val[1] = 1'b0; lp_val[2] = 1'b1; lp_val[3] = 1'b0; lp_val[4] = 1'b1; lp_val[5] = 1'b0;
    lp_pc[0] = 4'd1;  lp_pc[1] = 4'd0;  lp_pc[2] = 4'd1;  lp_pc[3] = 4'd0;  lp_pc[4] = 4'd1;  lp_pc[5] = 4'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_lp_op", instruction, lp_ops[i]);
      check("t6_lp_v",  instr_valid, lp_val[i]);
      check("t6_lp_pc", pc, lp_pc[i]);
    end
    check("t6_lp_busy", busy, 1'b0);
    tick(); check("t6_lp_done", done, 1'b1); check("t6_lp_endpc", pc, 4'd1);
`else
    for (int i = 0; i < 6; i++) begin
      lp_ops[i] = 4'h0; lp_val[i] = 1'b0; lp_pc[i] = 4'd0;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t6_op", instruction, t6_ops[i]);
      check("t6_v",  instr_valid, 1'b1);
    end
    check("t6_busy", busy, 1'b0);
    tick(); check("t6_done", done, 1'b1); check("t6_endpc", pc, 4'd15);
`endif
    tick(); check("t6_done_clr", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
